// File: rtl/md_velocity_pkg.sv
// Shared definitions for the ping-pong velocity store: default widths,
// FSM state encoding, read-path source select and the {vz, vy, vx} field layout.
package md_velocity_pkg;

  localparam int COMP_WIDTH_DEF   = 32;
  localparam int DATA_WIDTH_DEF   = 3 * COMP_WIDTH_DEF;
  localparam int ADDR_WIDTH_DEF   = 8;
  localparam int PARTICLE_NUM_DEF = 220;

  // Field offsets inside a packed velocity word; vx sits in the LSBs.
  localparam int VX_OFFSET = 0;
  localparam int VY_OFFSET = COMP_WIDTH_DEF;
  localparam int VZ_OFFSET = 2 * COMP_WIDTH_DEF;

  // Shadow-bank fill sequencing.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    FILLED = 2'd1,
    SWAP   = 2'd2
  } pp_state_e;

  // Where the registered read word comes from.
  typedef enum logic [1:0] {
    RD_ZERO  = 2'd0,
    RD_COUNT = 2'd1,
    RD_RAM   = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/velocity_bank_ram.sv
// One velocity bank: simple dual-port RAM, one write port, one read port
// with a single registered read stage that holds while rd_en is low.
module velocity_bank_ram #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 220,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Write port and registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/velocity_cell_pingpong.sv
// Double-buffered velocity store: readers see the active bank while the
// next iteration's velocities are appended into the shadow bank; a
// handshake swaps the two and publishes the new particle count.
module velocity_cell_pingpong
  import md_velocity_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int COMP_WIDTH   = COMP_WIDTH_DEF,
  parameter int PARTICLE_NUM = PARTICLE_NUM_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_bank,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  wr_overflow
);

  // wr_ptr needs one extra bit so it can sit at PARTICLE_NUM when full.
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] PNUM = PTR_W'(PARTICLE_NUM);

  if (DATA_WIDTH != 3 * COMP_WIDTH) begin : g_bad_data_width
    $error("DATA_WIDTH must equal 3*COMP_WIDTH");
  end
  if ((2 ** ADDR_WIDTH) < PARTICLE_NUM) begin : g_bad_addr_width
    $error("2**ADDR_WIDTH must cover PARTICLE_NUM");
  end

  pp_state_e             state_reg, state_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] shadow_count_reg, shadow_count_next;
  logic [ADDR_WIDTH-1:0] particle_count_reg, particle_count_next;
  logic                  active_bank_reg, active_bank_next;
  logic                  wr_overflow_reg, wr_overflow_next;
  logic                  swap_ack_reg, swap_ack_next;
  logic                  ram_we;

  // Read pipeline: what the request pointed at, captured with the request.
  logic                  rd_valid_reg;
  rd_sel_e               rd_sel_reg;
  logic                  rd_bank_reg;
  logic [ADDR_WIDTH-1:0] rd_count_reg;
  logic                  rd_addr_ok;

  logic [1:0]            bank_we;
  logic [1:0]            bank_re;
  logic [DATA_WIDTH-1:0] bank_q [2];

  // Next-state and datapath updates for the fill / filled / swap sequence.
  always_comb begin
    state_next          = state_reg;
    wr_ptr_next         = wr_ptr_reg;
    shadow_count_next   = shadow_count_reg;
    particle_count_next = particle_count_reg;
    active_bank_next    = active_bank_reg;
    wr_overflow_next    = wr_overflow_reg;
    swap_ack_next       = 1'b0;
    ram_we              = 1'b0;
    case (state_reg)
      FILL: begin
        if (wr_en) begin
          if (wr_ptr_reg < PNUM) begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
          end else begin
            wr_overflow_next = 1'b1;
          end
        end
        if (wr_last) begin
          // Count includes a write accepted on this same edge.
          state_next        = FILLED;
          shadow_count_next = ADDR_WIDTH'(wr_ptr_next - PTR_W'(1));
        end
      end
      FILLED: begin
        if (wr_en) begin
          wr_overflow_next = 1'b1;
        end
        if (swap_req) begin
          state_next = SWAP;
        end
      end
      SWAP: begin
        if (wr_en) begin
          wr_overflow_next = 1'b1;
        end
        state_next          = FILL;
        active_bank_next    = ~active_bank_reg;
        particle_count_next = shadow_count_reg;
        wr_ptr_next         = PTR_W'(1);
        shadow_count_next   = '0;
        swap_ack_next       = 1'b1;
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg          <= FILL;
      wr_ptr_reg         <= PTR_W'(1);
      shadow_count_reg   <= '0;
      particle_count_reg <= '0;
      active_bank_reg    <= 1'b0;
      wr_overflow_reg    <= 1'b0;
      swap_ack_reg       <= 1'b0;
    end else begin
      state_reg          <= state_next;
      wr_ptr_reg         <= wr_ptr_next;
      shadow_count_reg   <= shadow_count_next;
      particle_count_reg <= particle_count_next;
      active_bank_reg    <= active_bank_next;
      wr_overflow_reg    <= wr_overflow_next;
      swap_ack_reg       <= swap_ack_next;
    end
  end

  // Only addresses 1..count inside the bank reach the RAM; everything else reads zero.
  assign rd_addr_ok = (rd_addr != '0) && (rd_addr <= particle_count_reg) &&
                      ({1'b0, rd_addr} < PNUM);

  // Capture read source, bank and count at request time so a swap on the
  // same edge cannot redirect a read that was already issued.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_sel_reg   <= RD_ZERO;
      rd_bank_reg  <= 1'b0;
      rd_count_reg <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_bank_reg  <= active_bank_reg;
        rd_count_reg <= particle_count_reg;
        if (rd_addr == '0) begin
          rd_sel_reg <= RD_COUNT;
        end else if (rd_addr_ok) begin
          rd_sel_reg <= RD_RAM;
        end else begin
          rd_sel_reg <= RD_ZERO;
        end
      end
    end
  end

  // Two banks: reads target the active bank, writes the other one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = (gi == 1);

    assign bank_we[gi] = rst_n & ram_we & (active_bank_reg != BANK_ID);
    assign bank_re[gi] = rst_n & rd_en & rd_addr_ok & (active_bank_reg == BANK_ID);

    velocity_bank_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (PARTICLE_NUM),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .clock  (clock),
      .wr_en  (bank_we[gi]),
      .wr_addr(wr_ptr_reg[ADDR_WIDTH-1:0]),
      .wr_data(wr_data),
      .rd_en  (bank_re[gi]),
      .rd_addr(rd_addr),
      .rd_data(bank_q[gi])
    );
  end

  // Output select over registered sources; holds while no new read arrives.
  always_comb begin
    rd_data = '0;
    case (rd_sel_reg)
      RD_COUNT: rd_data = DATA_WIDTH'(rd_count_reg);
      RD_RAM:   rd_data = bank_q[rd_bank_reg];
      default:  rd_data = '0;
    endcase
  end

  assign rd_valid       = rd_valid_reg;
  assign swap_ack       = swap_ack_reg;
  assign active_bank    = active_bank_reg;
  assign particle_count = particle_count_reg;
  assign wr_overflow    = wr_overflow_reg;

endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// Directed bench for the ping-pong velocity store: a read-vector table plus
// hand-written swap, overflow and reset sequences.
module tb_velocity_cell_pingpong;
  import md_velocity_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          swap_req = 1'b0;
  logic          swap_ack;
  logic          active_bank;
  logic [AW-1:0] particle_count;
  logic          wr_overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [7];

  velocity_cell_pingpong dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .swap_req      (swap_req),
    .swap_ack      (swap_ack),
    .active_bank   (active_bank),
    .particle_count(particle_count),
    .wr_overflow   (wr_overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] word(int seed, int k);
    logic [DW-1:0] w;
    int base;
    base = seed * 1000 + k * 3;
    w = '0;
    w[VX_OFFSET +: COMP_WIDTH_DEF] = 32'(base);
    w[VY_OFFSET +: COMP_WIDTH_DEF] = 32'(base + 1);
    w[VZ_OFFSET +: COMP_WIDTH_DEF] = 32'(base + 2);
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    $display("read %s addr=%0d data=%h valid=%0b", name, addr, rd_data, rd_valid);
    check({name, "_valid"}, DW'(rd_valid), DW'(1));
    check({name, "_data"}, rd_data, exp);
  endtask

  task automatic wr_word(input logic [DW-1:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = last;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic fill(input int seed, input int n);
    for (int k = 1; k <= n; k++) begin
      wr_word(word(seed, k), k == n);
    end
    $display("fill seed=%0d words=%0d", seed, n);
  endtask

  // Expects the FSM to be in FILLED when called.
  task automatic do_swap(input string name, input int exp_count, input logic exp_bank);
    swap_req = 1'b1;
    tick();
    check({name, "_ack_early"}, DW'(swap_ack), DW'(0));
    tick();
    check({name, "_ack"}, DW'(swap_ack), DW'(1));
    check({name, "_bank"}, DW'(active_bank), DW'(exp_bank));
    check({name, "_count"}, DW'(particle_count), DW'(exp_count));
    swap_req = 1'b0;
    tick();
    check({name, "_ack_pulse"}, DW'(swap_ack), DW'(0));
    $display("swap %s bank=%0d count=%0d", name, active_bank, particle_count);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_bank"}, DW'(active_bank), DW'(0));
    check({name, "_count"}, DW'(particle_count), DW'(0));
    check({name, "_ovf"}, DW'(wr_overflow), DW'(0));
    check({name, "_ack"}, DW'(swap_ack), DW'(0));
    check({name, "_rvalid"}, DW'(rd_valid), DW'(0));
    check({name, "_rdata"}, rd_data, DW'(0));
  endtask

  initial begin
    vecs[0] = '{addr: 8'd0,   exp: DW'(5)};
    vecs[1] = '{addr: 8'd1,   exp: word(1, 1)};
    vecs[2] = '{addr: 8'd3,   exp: word(1, 3)};
    vecs[3] = '{addr: 8'd5,   exp: word(1, 5)};
    vecs[4] = '{addr: 8'd6,   exp: DW'(0)};
    vecs[5] = '{addr: 8'd200, exp: DW'(0)};
    vecs[6] = '{addr: 8'd250, exp: DW'(0)};

    // Reset state.
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Empty active bank after reset.
    do_read("empty_a0", 8'd0, DW'(0));
    do_read("empty_a1", 8'd1, DW'(0));

    // Five-word fill and swap into bank 1, then the read table.
    fill(1, 5);
    do_swap("swap5", 5, 1'b1);
    for (int i = 0; i < 7; i++) begin
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    tick();
    check("rvalid_drop", DW'(rd_valid), DW'(0));
    check("rdata_hold", rd_data, DW'(0));
    do_read("hold_src", 8'd2, word(1, 2));
    tick();
    check("rdata_hold2", rd_data, word(1, 2));

    // swap_req raised mid-fill stays pending until the fill closes.
    wr_word(word(2, 1), 1'b0);
    wr_word(word(2, 2), 1'b0);
    swap_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("pend_ack%0d", i), DW'(swap_ack), DW'(0));
    end
    wr_last = 1'b1;
    tick();
    wr_last = 1'b0;
    check("pend_ack_filled", DW'(swap_ack), DW'(0));
    do_swap("swap_pend", 2, 1'b0);
    do_read("pend_a2", 8'd2, word(2, 2));
    do_read("pend_a3", 8'd3, DW'(0));

    // Reads issued in the SWAP cycle and in the swap_ack cycle.
    fill(3, 3);
    swap_req = 1'b1;
    tick();
    rd_en   = 1'b1;
    rd_addr = 8'd1;
    tick();
    check("edge_ack", DW'(swap_ack), DW'(1));
    check("edge_old", rd_data, word(2, 1));
    swap_req = 1'b0;
    tick();
    rd_en = 1'b0;
    check("edge_new", rd_data, word(3, 1));
    $display("read edge addr=1 data=%h", rd_data);
    do_read("stale_a4", 8'd4, DW'(0));
    do_read("new_a3", 8'd3, word(3, 3));

    // Full bank: the PARTICLE_NUM-th write is dropped.
    for (int k = 1; k <= 220; k++) begin
      wr_word(word(4, k), k == 220);
      if (k == 219) begin
        check("ovf_before", DW'(wr_overflow), DW'(0));
      end
    end
    $display("fill seed=4 words=220");
    check("ovf_set", DW'(wr_overflow), DW'(1));
    do_swap("swap_full", 219, 1'b0);
    check("ovf_sticky", DW'(wr_overflow), DW'(1));
    do_read("full_a0", 8'd0, DW'(219));
    do_read("full_a1", 8'd1, word(4, 1));
    do_read("full_a219", 8'd219, word(4, 219));
    do_read("full_a220", 8'd220, DW'(0));

    // Reset in the middle of a fill, with reads/writes requested during reset.
    wr_word(word(6, 1), 1'b0);
    wr_word(word(6, 2), 1'b0);
    wr_word(word(6, 3), 1'b0);
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = word(6, 9);
    rd_en   = 1'b1;
    rd_addr = 8'd1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_reset_values("midreset");
    rst_n = 1'b1;
    tick();
    do_read("postrst_a1", 8'd1, DW'(0));
    fill(5, 2);
    do_swap("swap_postrst", 2, 1'b1);
    do_read("postrst_b2", 8'd2, word(5, 2));
    do_read("postrst_b3", 8'd3, DW'(0));

    // Write during the SWAP cycle is dropped and flagged.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fill(7, 1);
    swap_req = 1'b1;
    tick();
    check("swapwr_ovf_before", DW'(wr_overflow), DW'(0));
    wr_en   = 1'b1;
    wr_data = word(7, 2);
    tick();
    wr_en    = 1'b0;
    swap_req = 1'b0;
    check("swapwr_ack", DW'(swap_ack), DW'(1));
    check("swapwr_ovf", DW'(wr_overflow), DW'(1));
    check("swapwr_count", DW'(particle_count), DW'(1));
    do_read("swapwr_a1", 8'd1, word(7, 1));

    // Empty fill, write while FILLED, repeated wr_last ignored.
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    wr_last = 1'b1;
    tick();
    wr_last = 1'b0;
    check("filled_ovf_before", DW'(wr_overflow), DW'(0));
    wr_word(word(8, 1), 1'b1);
    check("filled_ovf", DW'(wr_overflow), DW'(1));
    do_swap("swap_empty", 0, 1'b1);
    do_read("empty_fill_a0", 8'd0, DW'(0));
    do_read("empty_fill_a1", 8'd1, DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
